// File: rtl/seg7_disp_pkg.sv
// Shared types and constants for the multiplexed 7-segment display path.
// Segment bit 0 is segment a and bit 6 is segment g.
package seg7_disp_pkg;

    typedef logic [6:0] seg_t;
    typedef logic [1:0] digit_idx_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } scan_state_t;

    localparam seg_t       SEG_ZERO  = 7'b0111111;
    localparam seg_t       SEG_BLANK = 7'h00;
    localparam logic [2:0] AN_OFF    = 3'b111;

endpackage

// File: rtl/seg7_scan_timer.sv
// Dwell/gap down-counter: load the last count value, then count down.
// The terminal-count output is high while the count sits at zero.
module seg7_scan_timer #(
    parameter int CW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          load_i,
    input  logic [CW-1:0] loadVal_i,
    output logic          tc_o
);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= loadVal_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for three 7-segment digits with inter-digit blanking,
// leading-zero suppression and tear-free pattern updates at frame boundaries.
module seg7_scan_driver
    import seg7_disp_pkg::*;
#(
    parameter int   DWELL_CYCLES   = 50000,
    parameter int   BLANK_CYCLES   = 1000,
    parameter bit   SEG_ACTIVE_LOW = 1'b0,
    parameter seg_t ZERO_PAT       = SEG_ZERO
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       load,
    input  logic [6:0] seg_units,
    input  logic [6:0] seg_tens,
    input  logic [6:0] seg_hund,
    input  logic       lz_blank,
    output logic [6:0] seg_out,
    output logic [2:0] an,
    output logic       frame_done
);

    localparam int            MAX_CYC    = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int            CW         = $clog2((MAX_CYC > 2) ? MAX_CYC : 2);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam seg_t          SEG_OFF    = SEG_ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;

    scan_state_t   state_q, state_d;
    digit_idx_t    idx_q, idx_d;
    seg_t          pendUnits_q, pendTens_q, pendHund_q;
    seg_t          pendUnits_d, pendTens_d, pendHund_d;
    seg_t          actUnits_q, actTens_q, actHund_q;
    seg_t          actUnits_d, actTens_d, actHund_d;
    seg_t          segOut_q, segOut_d;
    logic [2:0]    an_q, an_d;
    logic          frameDone_q, frameDone_d;
    logic          frameStart, advance;
    logic          timerClear, timerLoad, timerTc;
    logic [CW-1:0] timerVal;
    logic          hundBlank, tensBlank, digitBlank;
    seg_t          segPat, segLit;

    seg7_scan_timer #(.CW(CW)) u_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (timerClear),
        .load_i    (timerLoad),
        .loadVal_i (timerVal),
        .tc_o      (timerTc)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        frameStart  = 1'b0;
        frameDone_d = 1'b0;
        advance     = 1'b0;
        timerClear  = 1'b0;
        timerLoad   = 1'b0;
        timerVal    = DWELL_LAST;
        if (!en) begin
            state_d    = IDLE;
            idx_d      = '0;
            timerClear = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = ON;
                    idx_d      = '0;
                    frameStart = 1'b1;
                    timerLoad  = 1'b1;
                end
                ON: begin
                    if (timerTc) begin
                        if (BLANK_CYCLES > 0) begin
                            state_d   = GAP;
                            timerLoad = 1'b1;
                            timerVal  = GAP_LAST;
                        end else begin
                            advance = 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (timerTc) begin
                        advance = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
            // Leaving the hundreds slot wraps to units and opens a new frame.
            if (advance) begin
                state_d   = ON;
                timerLoad = 1'b1;
                timerVal  = DWELL_LAST;
                if (idx_q == 2'd2) begin
                    idx_d       = '0;
                    frameDone_d = 1'b1;
                    frameStart  = 1'b1;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
        end
    end

    // A load coinciding with a frame start bypasses the pending registers.
    always_comb begin
        pendUnits_d = load ? seg_units : pendUnits_q;
        pendTens_d  = load ? seg_tens  : pendTens_q;
        pendHund_d  = load ? seg_hund  : pendHund_q;
        actUnits_d  = actUnits_q;
        actTens_d   = actTens_q;
        actHund_d   = actHund_q;
        if (frameStart) begin
            actUnits_d = pendUnits_d;
            actTens_d  = pendTens_d;
            actHund_d  = pendHund_d;
        end
    end

    always_comb begin
        hundBlank = lz_blank && (actHund_d == ZERO_PAT);
        tensBlank = hundBlank && (actTens_d == ZERO_PAT);
        case (idx_d)
            2'd1:    begin segPat = actTens_d; digitBlank = tensBlank; end
            2'd2:    begin segPat = actHund_d; digitBlank = hundBlank; end
            default: begin segPat = actUnits_d; digitBlank = 1'b0;     end
        endcase
        segLit = ((state_d == ON) && !digitBlank) ? segPat : SEG_BLANK;
        segOut_d = SEG_ACTIVE_LOW ? ~segLit : segLit;
        if (state_d == ON) begin
            case (idx_d)
                2'd1:    an_d = 3'b101;
                2'd2:    an_d = 3'b011;
                default: an_d = 3'b110;
            endcase
        end else begin
            an_d = AN_OFF;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pendUnits_q <= ZERO_PAT;
            pendTens_q  <= ZERO_PAT;
            pendHund_q  <= ZERO_PAT;
            actUnits_q  <= ZERO_PAT;
            actTens_q   <= ZERO_PAT;
            actHund_q   <= ZERO_PAT;
            segOut_q    <= SEG_OFF;
            an_q        <= AN_OFF;
            frameDone_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            pendUnits_q <= pendUnits_d;
            pendTens_q  <= pendTens_d;
            pendHund_q  <= pendHund_d;
            actUnits_q  <= actUnits_d;
            actTens_q   <= actTens_d;
            actHund_q   <= actHund_d;
            segOut_q    <= segOut_d;
            an_q        <= an_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign seg_out    = segOut_q;
    assign an         = an_q;
    assign frame_done = frameDone_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: a vector table for the basic scan and
// pattern update, plus hand sequences for blanking, disable, bypass and reset.
module tb_seg7_scan_driver;
    import seg7_disp_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, en, load, lz_blank;
    seg_t       seg_units, seg_tens, seg_hund;
    seg_t       seg_out, seg_out0;
    logic [2:0] an, an0;
    logic       frame_done, frame_done0;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       load;
        logic       lz;
        seg_t       u;
        seg_t       t;
        seg_t       h;
        logic [2:0] an;
        seg_t       seg;
        logic       fd;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    seg7_scan_driver #(.DWELL_CYCLES(4), .BLANK_CYCLES(2), .SEG_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .seg_units(seg_units), .seg_tens(seg_tens), .seg_hund(seg_hund),
        .lz_blank(lz_blank), .seg_out(seg_out), .an(an), .frame_done(frame_done)
    );

    seg7_scan_driver #(.DWELL_CYCLES(4), .BLANK_CYCLES(0), .SEG_ACTIVE_LOW(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .load(load),
        .seg_units(seg_units), .seg_tens(seg_tens), .seg_hund(seg_hund),
        .lz_blank(lz_blank), .seg_out(seg_out0), .an(an0), .frame_done(frame_done0)
    );

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic [2:0] expAn, input seg_t expSeg,
                               input logic expFd);
        checkVal({name, ".an"}, 32'(an), 32'(expAn));
        checkVal({name, ".seg"}, 32'(seg_out), 32'(expSeg));
        checkVal({name, ".fd"}, 32'(frame_done), 32'(expFd));
    endtask

    task automatic applyStimulus(input vec_t v);
        en        = 1'b1;
        load      = v.load;
        lz_blank  = v.lz;
        seg_units = v.u;
        seg_tens  = v.t;
        seg_hund  = v.h;
        tick();
    endtask

    task automatic addVec(input int n, input logic ld, input seg_t u, input seg_t t, input seg_t h,
                          input logic [2:0] a, input seg_t s, input logic fd);
        vec_t v;
        v.load = ld; v.lz = 1'b0; v.u = u; v.t = t; v.h = h;
        v.an = a; v.seg = s; v.fd = fd;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    function automatic logic [2:0] anFor(input int slot);
        case (slot)
            0:       return 3'b110;
            1:       return 3'b101;
            default: return 3'b011;
        endcase
    endfunction

    task automatic doReset();
        rst_n = 1'b0; en = 1'b0; load = 1'b0; lz_blank = 1'b0;
        seg_units = 7'h00; seg_tens = 7'h00; seg_hund = 7'h00;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Checks one whole 18-cycle frame starting with the frame-start edge; load is a one-cycle strobe.
    task automatic checkFrame(input string name, input seg_t eu, input seg_t et, input seg_t eh,
                              input logic fdFirst);
        seg_t pats[3];
        pats[0] = eu; pats[1] = et; pats[2] = eh;
        for (int c = 0; c < 18; c++) begin
            int   slot;
            logic lit;
            tick();
            load = 1'b0;
            slot = c / 6;
            lit  = (c % 6) < 4;
            checkOutput($sformatf("%s.c%0d", name, c), lit ? anFor(slot) : 3'b111,
                        lit ? pats[slot] : 7'h00, (c == 0) ? fdFirst : 1'b0);
        end
    endtask

    initial begin
        seg_t z = 7'b0111111;

        doReset();
        rst_n = 1'b0;
        tick();
        checkOutput("reset", 3'b111, 7'h00, 1'b0);
        checkVal("reset.an0", 32'(an0), 32'(3'b111));
        rst_n = 1'b1;
        tick();
        checkOutput("idle", 3'b111, 7'h00, 1'b0);

        // Frame 1 shows zeros; frame 2 gets a load in its units slot; frame 3 shows 06/5B/4F.
        addVec(4, 0, z, z, z, 3'b110, z, 0);
        addVec(2, 0, z, z, z, 3'b111, 7'h00, 0);
        addVec(4, 0, z, z, z, 3'b101, z, 0);
        addVec(2, 0, z, z, z, 3'b111, 7'h00, 0);
        addVec(4, 0, z, z, z, 3'b011, z, 0);
        addVec(2, 0, z, z, z, 3'b111, 7'h00, 0);
        addVec(1, 0, z, z, z, 3'b110, z, 1);
        addVec(1, 1, 7'h06, 7'h5B, 7'h4F, 3'b110, z, 0);
        addVec(2, 0, z, z, z, 3'b110, z, 0);
        addVec(2, 0, z, z, z, 3'b111, 7'h00, 0);
        addVec(4, 0, z, z, z, 3'b101, z, 0);
        addVec(2, 0, z, z, z, 3'b111, 7'h00, 0);
        addVec(4, 0, z, z, z, 3'b011, z, 0);
        addVec(2, 0, z, z, z, 3'b111, 7'h00, 0);
        addVec(1, 0, z, z, z, 3'b110, 7'h06, 1);
        addVec(3, 0, z, z, z, 3'b110, 7'h06, 0);
        addVec(2, 0, z, z, z, 3'b111, 7'h00, 0);
        addVec(4, 0, z, z, z, 3'b101, 7'h5B, 0);
        addVec(2, 0, z, z, z, 3'b111, 7'h00, 0);
        addVec(4, 0, z, z, z, 3'b011, 7'h4F, 0);
        addVec(2, 0, z, z, z, 3'b111, 7'h00, 0);
        addVec(1, 0, z, z, z, 3'b110, 7'h06, 1);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d", i + 1), vecs[i].an, vecs[i].seg, vecs[i].fd);
        end

        // Leading-zero blanking, loaded via the frame-start bypass.
        doReset();
        en = 1'b1; load = 1'b1; lz_blank = 1'b1;
        seg_units = 7'b0000111; seg_tens = z; seg_hund = z;
        checkFrame("lz007", 7'h07, 7'h00, 7'h00, 1'b0);
        load = 1'b1; seg_tens = 7'b1011011;
        checkFrame("lz027", 7'h07, 7'h5B, 7'h00, 1'b1);
        lz_blank = 1'b0;
        checkFrame("nolz", 7'h07, 7'h5B, z, 1'b1);

        // Disable in the tens slot, then re-enable.
        doReset();
        en = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        checkOutput("dis.before", 3'b101, z, 1'b0);
        en = 1'b0;
        tick();
        checkOutput("dis.off", 3'b111, 7'h00, 1'b0);
        for (int i = 0; i < 12; i++) begin
            tick();
            checkOutput($sformatf("dis.idle%0d", i), 3'b111, 7'h00, 1'b0);
        end
        en = 1'b1;
        checkFrame("reen", z, z, z, 1'b0);

        // load and en rising together.
        doReset();
        en = 1'b1; load = 1'b1; seg_units = 7'b1111111; seg_tens = z; seg_hund = z;
        checkFrame("bypass", 7'h7F, z, z, 1'b0);

        // Asynchronous reset in the middle of a lit slot.
        doReset();
        en = 1'b1; load = 1'b1; seg_units = 7'h06; seg_tens = 7'h5B; seg_hund = 7'h4F;
        tick();
        load = 1'b0;
        checkOutput("rst.lit", 3'b110, 7'h06, 1'b0);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst.async", 3'b111, 7'h00, 1'b0);
        tick();
        rst_n = 1'b1;
        checkFrame("rst.after", z, z, z, 1'b0);

        // Zero-gap instance: 12-clock frames with no dark cycles.
        doReset();
        en = 1'b1;
        for (int c = 0; c < 13; c++) begin
            tick();
            checkVal($sformatf("nogap.an%0d", c), 32'(an0), 32'((c < 12) ? anFor(c / 4) : 3'b110));
            checkVal($sformatf("nogap.seg%0d", c), 32'(seg_out0), 32'(z));
            checkVal($sformatf("nogap.fd%0d", c), 32'(frame_done0), 32'(c == 12));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
